// File: rtl/sigmoid_backward_pkg.sv
// sigmoid_backward_pkg
//   Fixed-point definitions shared by the forward sigmoid and its backward
//   pass: word widths, the ONE constant, the signed word type and the
//   activation clamp helper.
package sigmoid_backward_pkg;

  localparam int DATA_LEN = 32;            // total word width
  localparam int FRAC_LEN = 16;            // fractional bits
  localparam int UFRAC_W  = FRAC_LEN + 1;  // holds any value in [0, ONE]

  typedef logic signed [DATA_LEN-1:0] fxp_t;
  typedef logic        [UFRAC_W-1:0]  ufrac_t;

  localparam ufrac_t ONE_U = ufrac_t'(1) << FRAC_LEN;
  localparam fxp_t   ONE   = fxp_t'(ONE_U);

  typedef struct packed {
    ufrac_t s_c;      // activation clamped to [0, ONE]
    logic   clamped;  // activation lay outside [0, ONE]
  } clamp_t;

  // A saved activation outside [0, 1.0] can only come from a corrupted
  // store or a rounding excursion; pin it to the nearest legal value.
  function automatic clamp_t clamp_unit(input fxp_t s);
    clamp_t r;
    r.s_c     = s[UFRAC_W-1:0];
    r.clamped = 1'b0;
    if (s < 0) begin
      r.s_c     = '0;
      r.clamped = 1'b1;
    end else if (s > ONE) begin
      r.s_c     = ONE_U;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sigmoid_backward_fxp_mul.sv
// sigmoid_backward_fxp_mul
//   Registered signed x signed multiply followed by an arithmetic right shift
//   (truncation toward minus infinity) and truncation to O_W bits.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears the result)
//   en         : stall enable; the result register holds while low
//   a_i, b_i   : signed operands
//   p_o        : registered (a_i * b_i) >>> SHIFT, low O_W bits
module sigmoid_backward_fxp_mul #(
  parameter int A_W   = 32,
  parameter int B_W   = 17,
  parameter int O_W   = 32,
  parameter int SHIFT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic signed [A_W-1:0] a_i,
  input  logic signed [B_W-1:0] b_i,
  output logic signed [O_W-1:0] p_o
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] prod;
  logic signed [O_W-1:0] p_d;
  logic signed [O_W-1:0] p_q;

  // Full-width product, so no bits are lost before the shift.
  assign prod = P_W'(a_i) * P_W'(b_i);
  assign p_d  = O_W'(prod >>> SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
    end else if (en) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/sigmoid_backward.sv
// sigmoid_backward
//   Three-stage backward pass of the sigmoid: out_grad = g * s * (1 - s)
//   in the signed fixed-point format of the forward sigmoid.
//     S1: clamp s to [0, ONE], t = ONE - s_c
//     S2: p = (s_c * t) >> FRAC_LEN          (0 <= p <= ONE/4)
//     S3: r = (g * p) >>> FRAC_LEN           (|r| <= |g|/4, never overflows)
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   in_valid/in_ready  : input handshake for in_act (s) and in_grad (g)
//   out_valid/out_ready: output handshake for out_grad and out_clamp
//   out_clamp          : the activation of this result had to be clamped
module sigmoid_backward
  import sigmoid_backward_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_act,
  input  logic [DATA_LEN-1:0] in_grad,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_grad,
  output logic                out_clamp
);

  // Whole pipeline moves in lockstep: it advances unless a valid result is
  // sitting at the output and is not being taken.
  logic adv;

  clamp_t clamp_d;
  ufrac_t t_d;

  // S1 registers
  logic   v1_q;
  ufrac_t s_c_q;
  ufrac_t t_q;
  fxp_t   g1_q;
  logic   c1_q;

  // S2 registers (p lives inside the S2 multiplier)
  logic   v2_q;
  fxp_t   g2_q;
  logic   c2_q;

  // S3 registers (r lives inside the S3 multiplier)
  logic   v3_q;
  logic   c3_q;

  logic signed [UFRAC_W-1:0] p_w;
  fxp_t                      r_w;

  assign adv      = !v3_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    clamp_d = clamp_unit($signed(in_act));
    t_d     = ONE_U - clamp_d.s_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      s_c_q <= '0;
      t_q   <= '0;
      g1_q  <= '0;
      c1_q  <= 1'b0;
      v2_q  <= 1'b0;
      g2_q  <= '0;
      c2_q  <= 1'b0;
      v3_q  <= 1'b0;
      c3_q  <= 1'b0;
    end else if (adv) begin
      // With adv high in_ready is high, so in_valid alone marks a transfer.
      v1_q  <= in_valid;
      s_c_q <= clamp_d.s_c;
      t_q   <= t_d;
      g1_q  <= $signed(in_grad);
      c1_q  <= clamp_d.clamped;
      v2_q  <= v1_q;
      g2_q  <= g1_q;
      c2_q  <= c1_q;
      v3_q  <= v2_q;
      c3_q  <= c2_q;
    end
  end

  // s_c and t are non-negative; a zero sign bit makes the signed multiplier
  // compute the unsigned product. p <= ONE/4 so its top bit is always zero.
  sigmoid_backward_fxp_mul #(
    .A_W  (UFRAC_W + 1),
    .B_W  (UFRAC_W + 1),
    .O_W  (UFRAC_W),
    .SHIFT(FRAC_LEN)
  ) u_mul_s2 (
    .clk  (clk),
    .reset(reset),
    .en   (adv),
    .a_i  ($signed({1'b0, s_c_q})),
    .b_i  ($signed({1'b0, t_q})),
    .p_o  (p_w)
  );

  sigmoid_backward_fxp_mul #(
    .A_W  (DATA_LEN),
    .B_W  (UFRAC_W),
    .O_W  (DATA_LEN),
    .SHIFT(FRAC_LEN)
  ) u_mul_s3 (
    .clk  (clk),
    .reset(reset),
    .en   (adv),
    .a_i  (g2_q),
    .b_i  (p_w),
    .p_o  (r_w)
  );

  assign out_valid = v3_q;
  assign out_grad  = r_w;
  assign out_clamp = c3_q;

endmodule

// File: tb/tb_sigmoid_backward.sv
module tb_sigmoid_backward;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_act;
  logic [31:0] in_grad;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_grad;
  logic        out_clamp;

  int tests_run    = 0;
  int tests_failed = 0;

  // Directed vectors: activation, gradient, expected result, expected clamp.
  logic [31:0] vs [8];
  logic [31:0] vg [8];
  logic [31:0] ve [8];
  logic        vc [8];

  always #5 clk = ~clk;

  sigmoid_backward dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_act   (in_act),
    .in_grad  (in_grad),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_grad (out_grad),
    .out_clamp(out_clamp)
  );

  // One isolated transaction from an empty pipeline; entered and left at a
  // falling edge with out_ready = 1.
  task automatic do_single(input string name, input logic [31:0] s,
                           input logic [31:0] g, input logic [31:0] e,
                           input logic c);
    in_act   = s;
    in_grad  = g;
    in_valid = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_in_ready: got %b, expected 1", name, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_act   = 32'hDEAD_BEEF;
    in_grad  = 32'hDEAD_BEEF;
    // Result becomes visible after the third edge, counting the accepting one.
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin
        @(posedge clk);
        @(negedge clk);
      end
      #1;
      tests_run++;
      if (out_valid !== 1'(k == 3)) begin
        tests_failed++;
        $display("FAIL %s_latency: out_valid=%b after edge %0d, expected %b",
                 name, out_valid, k, (k == 3));
      end
    end
    tests_run++;
    if (out_grad !== e) begin
      tests_failed++;
      $display("FAIL %s_grad: got %h, expected %h", name, out_grad, e);
    end
    tests_run++;
    if (out_clamp !== c) begin
      tests_failed++;
      $display("FAIL %s_clamp: got %b, expected %b", name, out_clamp, c);
    end
    $display("[TB] %s: s=%h g=%h -> out_grad=%h clamp=%b", name, s, g, out_grad, out_clamp);
    @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_drained: out_valid=%b, expected 0", name, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_act    = '0;
    in_grad   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
    end
    tests_run++;
    if (out_grad !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_out_grad: got %h, expected 00000000", out_grad);
    end
    tests_run++;
    if (out_clamp !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_clamp: got %b, expected 0", out_clamp);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    $display("[TB] reset: out_valid=%b out_grad=%h in_ready=%b", out_valid, out_grad, in_ready);
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_single("half_unit", 32'h0000_8000, 32'h0001_0000, 32'h0000_4000, 1'b0);
    do_single("neg_grad",  32'h0000_C000, 32'hFFFE_0000, 32'hFFFF_A000, 1'b0);
    do_single("big_grad",  32'h0000_C000, 32'h0004_0000, 32'h0000_C000, 1'b0);
  endtask

  task automatic test_clamp();
    do_single("clamp_neg", 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0000, 1'b1);
    do_single("clamp_big", 32'h0002_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    do_single("edge_one",  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0);
    do_single("edge_zero", 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 1'b0);
  endtask

  task automatic test_truncation();
    // p = 12288; -1 * 12288 / 65536 floors to -1, +1 * 12288 / 65536 to 0.
    do_single("trunc_neg", 32'h0000_4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_single("trunc_pos", 32'h0000_4000, 32'h0000_0001, 32'h0000_0000, 1'b0);
    do_single("quarter",   32'h0000_4000, 32'h0001_0000, 32'h0000_3000, 1'b0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        in_act   = vs[c];
        in_grad  = vg[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_in_ready: cycle %0d got %b, expected 1", c, in_ready);
      end
      if (c >= 3 && c < 11) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_grad !== ve[c-3] || out_clamp !== vc[c-3]) begin
          tests_failed++;
          $display("FAIL stream_item%0d: valid=%b grad=%h clamp=%b, expected valid=1 grad=%h clamp=%b",
                   c - 3, out_valid, out_grad, out_clamp, ve[c-3], vc[c-3]);
        end
        $display("[TB] stream item %0d: out_grad=%h clamp=%b", c - 3, out_grad, out_clamp);
      end else begin
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream_gap: cycle %0d out_valid=%b, expected 0", c, out_valid);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int   idx;
    int   got;
    logic rdy;
    idx       = 0;
    got       = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (idx < 5) begin
        in_valid = 1'b1;
        in_act   = vs[idx];
        in_grad  = vg[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      rdy = in_ready;
      if (cyc >= 3) begin
        tests_run++;
        if (in_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL bp_in_ready: cycle %0d got %b, expected 0", cyc, in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_grad !== ve[0] || out_clamp !== vc[0]) begin
          tests_failed++;
          $display("FAIL bp_hold: cycle %0d valid=%b grad=%h, expected valid=1 grad=%h",
                   cyc, out_valid, out_grad, ve[0]);
        end
      end
      @(posedge clk);
      if (in_valid && rdy) idx++;
      @(negedge clk);
    end
    tests_run++;
    if (idx !== 3) begin
      tests_failed++;
      $display("FAIL bp_absorbed: accepted %0d items, expected 3", idx);
    end
    $display("[TB] backpressure: %0d items absorbed while stalled", idx);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      if (idx < 5) begin
        in_valid = 1'b1;
        in_act   = vs[idx];
        in_grad  = vg[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      rdy = in_ready;
      if (out_valid) begin
        tests_run++;
        if (out_grad !== ve[got] || out_clamp !== vc[got]) begin
          tests_failed++;
          $display("FAIL bp_drain%0d: grad=%h clamp=%b, expected grad=%h clamp=%b",
                   got, out_grad, out_clamp, ve[got], vc[got]);
        end
        $display("[TB] drain item %0d: out_grad=%h clamp=%b", got, out_grad, out_clamp);
        got++;
      end
      @(posedge clk);
      if (in_valid && rdy) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++;
    if (got !== 5) begin
      tests_failed++;
      $display("FAIL bp_drain_count: drained %0d items, expected 5", got);
    end
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty: out_valid=%b after drain, expected 0", out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_act   = vs[c];
      in_grad  = vg[c];
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_out_valid: got %b, expected 0", out_valid);
    end
    $display("[TB] reset with 3 in flight: out_valid=%b", out_valid);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_stale: cycle %0d out_valid=%b grad=%h, expected 0",
                 c, out_valid, out_grad);
      end
    end
    @(negedge clk);
    do_single("after_reset", 32'h0000_C000, 32'hFFFE_0000, 32'hFFFF_A000, 1'b0);
  endtask

  initial begin
    vs[0] = 32'h0000_8000; vg[0] = 32'h0001_0000; ve[0] = 32'h0000_4000; vc[0] = 1'b0;
    vs[1] = 32'h0000_C000; vg[1] = 32'hFFFE_0000; ve[1] = 32'hFFFF_A000; vc[1] = 1'b0;
    vs[2] = 32'h0000_4000; vg[2] = 32'hFFFF_FFFF; ve[2] = 32'hFFFF_FFFF; vc[2] = 1'b0;
    vs[3] = 32'h0000_4000; vg[3] = 32'h0000_0001; ve[3] = 32'h0000_0000; vc[3] = 1'b0;
    vs[4] = 32'h0001_0000; vg[4] = 32'h0000_3039; ve[4] = 32'h0000_0000; vc[4] = 1'b0;
    vs[5] = 32'h0000_C000; vg[5] = 32'h0004_0000; ve[5] = 32'h0000_C000; vc[5] = 1'b0;
    vs[6] = 32'hFFFF_FFFF; vg[6] = 32'h0001_0000; ve[6] = 32'h0000_0000; vc[6] = 1'b1;
    vs[7] = 32'h0000_8000; vg[7] = 32'hFFFF_0000; ve[7] = 32'hFFFF_C000; vc[7] = 1'b0;

    @(negedge clk);
    test_reset();
    test_basic();
    test_clamp();
    test_truncation();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
